// File: rtl/rosc_bank.sv
// rtl/rosc_bank.sv - bank of ring-oscillator delta configs feeding one entropy source and a word collector
module rosc_bank #(
    parameter int NUM_OSC = 4,
    parameter int SEL_W   = $clog2(NUM_OSC),
    parameter int DW      = 32,
    parameter int ADDR_W  = 8,
    parameter int WARMUP  = 16,
    parameter int OUT_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rosc_en,
    input  logic [SEL_W-1:0]  rosc_sel,
    input  logic              scanmode,
    input  logic              p_sel,
    input  logic              p_rd,
    input  logic              p_wr,
    input  logic [ADDR_W-1:0] p_ad,
    input  logic [DW-1:0]     p_wdata,
    output logic [DW-1:0]     p_rdata,
    output logic              rosc_out,
    output logic [OUT_W-1:0]  rnd_data,
    output logic              rnd_valid,
    input  logic              rnd_ready
);
    localparam int WW   = ADDR_W - 2;
    localparam int CW   = $clog2(OUT_W);
    localparam int WU_W = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);
    localparam logic [WW-1:0] W_STATUS = WW'(2 * NUM_OSC);
    localparam logic [WW-1:0] W_DATA   = WW'(2 * NUM_OSC + 1);

    logic [DW-1:0]    deltax [NUM_OSC];
    logic [DW-1:0]    deltay [NUM_OSC];
    logic [WW-1:0]    w;
    logic [SEL_W-1:0] w_ch;
    logic             wr_en, rd_en, w_is_delta;
    logic             entropy_reset, restart_evt;
    logic [SEL_W-1:0] rosc_sel_s;
    logic             rosc_en_s;
    logic [WU_W-1:0]  warm_cnt;
    logic [CW-1:0]    bit_cnt;
    logic [OUT_W-2:0] shreg;
    logic [OUT_W-1:0] shreg_next;
    logic             slot_free, at_last, stall, sample, load;
    logic [DW-1:0]    status, data_ext, rdata_mux;
    logic             unused_ok;

    assign w          = p_ad[ADDR_W-1:2];
    assign w_ch       = w[SEL_W:1];
    assign wr_en      = p_sel & p_wr;
    assign rd_en      = p_sel & p_rd & ~p_wr;
    assign w_is_delta = (w < W_STATUS);
    assign unused_ok  = &{1'b0, p_ad[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_OSC; i++) begin
                deltax[i] <= DW'(40 + 4 * i);
                deltay[i] <= DW'(32 + 4 * i);
            end
        end else if (wr_en && w_is_delta) begin
            if (w[0]) deltay[w_ch] <= p_wdata;
            else      deltax[w_ch] <= p_wdata;
        end
    end

    // Only touching the live channel's deltas perturbs the running oscillator.
    assign restart_evt = (wr_en & w_is_delta & (w_ch == rosc_sel))
                       | (rosc_sel != rosc_sel_s)
                       | (rosc_en & ~rosc_en_s)
                       | scanmode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entropy_reset <= 1'b1;
            rosc_sel_s    <= '0;
            rosc_en_s     <= 1'b0;
        end else begin
            entropy_reset <= restart_evt;
            rosc_sel_s    <= rosc_sel;
            rosc_en_s     <= rosc_en;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         warm_cnt <= WU_W'(WARMUP);
        else if (entropy_reset)             warm_cnt <= WU_W'(WARMUP);
        else if (rosc_en && warm_cnt != '0) warm_cnt <= warm_cnt - 1'b1;
    end

    assign slot_free  = ~rnd_valid | rnd_ready;
    assign at_last    = (bit_cnt == CW'(OUT_W - 1));
    assign stall      = at_last & ~slot_free;
    assign sample     = rosc_en & ~entropy_reset & (warm_cnt == '0) & ~scanmode & ~stall;
    assign load       = sample & at_last;
    assign shreg_next = {shreg, rosc_out};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (entropy_reset) begin
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (sample) begin
            shreg   <= shreg_next[OUT_W-2:0];
            bit_cnt <= at_last ? '0 : bit_cnt + 1'b1;
        end
    end

    // A pending word survives restarts; only the consumer retires it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rnd_data  <= '0;
            rnd_valid <= 1'b0;
        end else if (load) begin
            rnd_data  <= shreg_next;
            rnd_valid <= 1'b1;
        end else if (rnd_ready) begin
            rnd_valid <= 1'b0;
        end
    end

    generate
        if (OUT_W >= DW) begin : g_data_trunc
            assign data_ext = rnd_data[DW-1:0];
        end else begin : g_data_ext
            assign data_ext = {{(DW - OUT_W){1'b0}}, rnd_data};
        end
    endgenerate

    always_comb begin
        status             = '0;
        status[0]          = rnd_valid;
        status[1]          = (warm_cnt != '0);
        status[2]          = entropy_reset;
        status[3 +: SEL_W] = rosc_sel;
    end

    always_comb begin
        rdata_mux = '0;
        if (w_is_delta)          rdata_mux = w[0] ? deltay[w_ch] : deltax[w_ch];
        else if (w == W_STATUS)  rdata_mux = status;
        else if (w == W_DATA)    rdata_mux = data_ext;
    end

    assign p_rdata = rd_en ? rdata_mux : '0;

    entropy_gen #(.DW(DW)) u_gen (
        .clk        (clk),
        .rst        (entropy_reset),
        .enb        (rosc_en),
        .osc_deltax (deltax[rosc_sel]),
        .osc_deltay (deltay[rosc_sel]),
        .out        (rosc_out)
    );
endmodule

// Synthesizable stand-in for the oscillator: high/low phase lengths follow deltax/deltay, mixed with an LFSR.
module entropy_gen #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enb,
    input  logic [DW-1:0] osc_deltax,
    input  logic [DW-1:0] osc_deltay,
    output logic          out
);
    logic [15:0]   lfsr;
    logic [DW-1:0] phase;
    logic          level;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr  <= (16'hACE1 ^ {osc_deltax[7:0], osc_deltay[7:0]}) | 16'h0001;
            phase <= '0;
            level <= 1'b0;
            out   <= 1'b0;
        end else if (enb) begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            if (phase >= (level ? osc_deltay : osc_deltax)) begin
                phase <= '0;
                level <= ~level;
            end else begin
                phase <= phase + 1'b1;
            end
            out <= level ^ lfsr[15];
        end
    end
endmodule

// File: tb/tb_rosc_bank.sv
// tb/tb_rosc_bank.sv - directed self-checking bench for rosc_bank
`timescale 1ns/100ps
module tb_rosc_bank;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        rosc_en;
    logic [1:0]  rosc_sel;
    logic        scanmode;
    logic        p_sel, p_rd, p_wr;
    logic [7:0]  p_ad;
    logic [31:0] p_wdata;
    logic [31:0] p_rdata;
    logic        rosc_out;
    logic [31:0] rnd_data;
    logic        rnd_valid;
    logic        rnd_ready;

    int n_tests = 0;
    int n_fail  = 0;

    rosc_bank #(.NUM_OSC(4), .DW(32), .ADDR_W(8), .WARMUP(16), .OUT_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rosc_en   (rosc_en),
        .rosc_sel  (rosc_sel),
        .scanmode  (scanmode),
        .p_sel     (p_sel),
        .p_rd      (p_rd),
        .p_wr      (p_wr),
        .p_ad      (p_ad),
        .p_wdata   (p_wdata),
        .p_rdata   (p_rdata),
        .rosc_out  (rosc_out),
        .rnd_data  (rnd_data),
        .rnd_valid (rnd_valid),
        .rnd_ready (rnd_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic bus_read(input int w, output logic [31:0] d);
        p_sel = 1'b1; p_rd = 1'b1; p_ad = 8'(w * 4);
        #1;
        d = p_rdata;
        p_sel = 1'b0; p_rd = 1'b0;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic bus_write(input int w, input logic [31:0] d);
        p_sel = 1'b1; p_wr = 1'b1; p_ad = 8'(w * 4); p_wdata = d;
        @(posedge clk); #1;
        p_sel = 1'b0; p_wr = 1'b0;
        @(negedge clk);
    endtask

    logic [31:0] rd;
    logic [31:0] exp_rst [8] = '{40, 32, 44, 36, 48, 40, 52, 44};
    logic [31:0] exp_end [8] = '{40, 32, 44, 70, 100, 40, 52, 44};
    logic        bits [1:60];
    logic [31:0] exp_w, hold_d, dp;
    logic        b;
    int          first, c0, hold_bad;
    bit          found;

    initial begin
        rst_n = 1'b0; rosc_en = 1'b0; rosc_sel = 2'd0; scanmode = 1'b0;
        p_sel = 1'b0; p_rd = 1'b0; p_wr = 1'b0; p_ad = '0; p_wdata = '0;
        rnd_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        bus_read(8, rd);
        check("rst_status", rd, 32'h6);
        for (int i = 0; i < 8; i++) begin
            bus_read(i, rd);
            check($sformatf("rst_reg%0d", i), rd, exp_rst[i]);
        end
        check("rst_valid", rnd_valid, 1'b0);
        check("rst_data", rnd_data, 32'h0);

        // Startup latency from reset with rosc_en already high
        @(negedge clk);
        rst_n = 1'b0; rosc_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        first = 0;
        for (int k = 1; k <= 60; k++) begin
            bits[k] = rosc_out;
            @(posedge clk); #1;
            if (rnd_valid) begin
                first = k;
                break;
            end
            @(negedge clk);
        end
        exp_w = '0;
        for (int k = 19; k <= 50; k++) exp_w = {exp_w[30:0], bits[k]};
        check("latency_edge", first, 50);
        check("first_word", rnd_data, exp_w);
        @(negedge clk);

        // Selective restart
        rosc_sel = 2'd1;
        repeat (25) @(negedge clk);
        bus_read(8, rd);
        check("sel1_settled", rd[2:1], 2'b00);
        c0 = int'(dut.bit_cnt);
        bus_write(4, 32'd100);
        bus_read(8, rd);
        check("other_ch_no_reset", rd[2], 1'b0);
        check("other_ch_cnt", dut.bit_cnt, (c0 == 31) ? 0 : c0 + 1);
        bus_read(4, rd);
        check("dx2_readback", rd, 32'd100);
        bus_write(3, 32'd70);
        bus_read(8, rd);
        check("sel_ch_reset", rd[2], 1'b1);
        @(negedge clk);
        bus_read(8, rd);
        check("warm_start", rd[2:1], 2'b01);
        check("warm_cnt_clr", dut.bit_cnt, 0);
        repeat (15) @(negedge clk);
        bus_read(8, rd);
        check("warm_16th", rd[1], 1'b1);
        @(negedge clk);
        bus_read(8, rd);
        check("warm_done", rd[1], 1'b0);

        // Back-pressure
        rnd_ready = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (rnd_valid) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("bp_word_seen", found, 1'b1);
        hold_d = rnd_data;
        hold_bad = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (rnd_data !== hold_d || rnd_valid !== 1'b1) hold_bad++;
        end
        check("bp_hold_stable", hold_bad, 0);
        check("bp_stall_cnt", dut.bit_cnt, 31);
        b = rosc_out;
        rnd_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_reload_valid", rnd_valid, 1'b1);
        check("bp_reload_lsb", rnd_data[0], b);
        check("bp_reload_cnt", dut.bit_cnt, 0);
        @(negedge clk);

        // Sel change mid-word with a pending word
        rosc_sel = 2'd0;
        repeat (25) @(negedge clk);
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (rnd_valid) begin
                rnd_ready = 1'b0;
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("mid_word_seen", found, 1'b1);
        dp = rnd_data;
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (dut.bit_cnt == 10) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("mid_cnt10", found, 1'b1);
        rosc_sel = 2'd3;
        repeat (2) @(negedge clk);
        check("sel3_cnt_clr", dut.bit_cnt, 0);
        check("sel3_valid_kept", rnd_valid, 1'b1);
        check("sel3_data_kept", rnd_data, dp);
        check("sel3_deltax", dut.u_gen.osc_deltax, 32'd52);
        check("sel3_deltay", dut.u_gen.osc_deltay, 32'd44);
        bus_read(8, rd);
        check("sel3_status_sel", rd[4:3], 2'd3);

        // Scan mode
        scanmode = 1'b1;
        repeat (2) @(negedge clk);
        bus_read(8, rd);
        check("scan_reset", rd[2], 1'b1);
        repeat (10) @(negedge clk);
        bus_read(8, rd);
        check("scan_reset_held", rd[2], 1'b1);
        check("scan_no_sample", dut.bit_cnt, 0);
        check("scan_valid", rnd_valid, 1'b1);
        check("scan_data", rnd_data, dp);
        scanmode = 1'b0;
        @(negedge clk);

        // Unmapped write/read
        bus_write(20, 32'hDEADBEEF);
        bus_read(20, rd);
        check("unmapped_rd", rd, 32'h0);
        for (int i = 0; i < 8; i++) begin
            bus_read(i, rd);
            check($sformatf("end_reg%0d", i), rd, exp_end[i]);
        end
        bus_read(9, rd);
        check("data_reg", rd, dp);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
